// File: rtl/cmp_minmax_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_minmax_seq_pkg
// Purpose  : Shared definitions for the sequential min/max burst tracker:
//            FSM state type, comparator result codes and parameter defaults.
// Ports    : none (package)
// Options  : CMP_MINMAX_IDX_EN (consumed by cmp_minmax_seq, not used here)
// Revision : 1.0 - initial release
// ============================================================================
package cmp_minmax_seq_pkg;

   localparam int W_DEFAULT     = 5;
   localparam int CNT_W_DEFAULT = 4;

   // Comparator result codes (a relative to b)
   localparam logic [1:0] CMP_EQZ = 2'b00;  // a == b == 0
   localparam logic [1:0] CMP_GT  = 2'b01;  // a >  b
   localparam logic [1:0] CMP_LT  = 2'b10;  // a <  b
   localparam logic [1:0] CMP_EQ  = 2'b11;  // a == b != 0

   typedef enum logic [1:0] {
      ACCEPT  = 2'd0,
      CMP_MAX = 2'd1,
      CMP_MIN = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage : cmp_minmax_seq_pkg
`default_nettype wire

// File: rtl/mag_cmp5.sv
`default_nettype none
// ============================================================================
// Module   : mag_cmp5
// Purpose  : Combinational unsigned magnitude comparator producing a 2-bit
//            relation code (EQZ / GT / LT / EQ).
// Ports    : a, b  - W-bit unsigned operands
//            code  - relation of a to b
// Revision : 1.0 - initial release
// ============================================================================
module mag_cmp5
   import cmp_minmax_seq_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [1:0]   code
);

   always_comb begin
      code = CMP_GT;
      if (a == b) begin
         // Equality is split so callers can tell an all-zero match apart
         code = (a == '0) ? CMP_EQZ : CMP_EQ;
      end else if (a < b) begin
         code = CMP_LT;
      end
   end

endmodule : mag_cmp5
`default_nettype wire

// File: rtl/cmp_minmax_seq.sv
`default_nettype none
// ============================================================================
// Module   : cmp_minmax_seq
// Purpose  : Tracks maximum, minimum and sample count of a burst of samples
//            using a single shared comparator (one compare per FSM step).
// Ports    : clk, rst_n (async, active-low)
//            in_data/in_valid/in_last/in_ready - sample input handshake
//            max_val/min_val/count/ovf         - burst result
//            res_valid                         - result is complete
//            done                              - one-cycle completion pulse
//            max_idx/min_idx                   - extremum indices (option)
// Options  : CMP_MINMAX_IDX_EN adds max_idx/min_idx outputs
// Revision : 1.0 - initial release
// ============================================================================
module cmp_minmax_seq
   import cmp_minmax_seq_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [W-1:0]     max_val,
   output logic [W-1:0]     min_val,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   output logic             res_valid,
`ifdef CMP_MINMAX_IDX_EN
   output logic [CNT_W-1:0] max_idx,
   output logic [CNT_W-1:0] min_idx,
`endif
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [W-1:0]     smp_q, smp_d;
   logic [W-1:0]     max_q, max_d;
   logic [W-1:0]     min_q, min_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;          // live burst counter
   logic [CNT_W-1:0] cnt_res_q, cnt_res_d;  // count of the last finished burst
   logic             ovf_q, ovf_d;
   logic             res_valid_q, res_valid_d;
   logic             done_q, done_d;
   logic             last_q, last_d;
`ifdef CMP_MINMAX_IDX_EN
   logic [CNT_W-1:0] smp_idx_q, smp_idx_d;
   logic [CNT_W-1:0] max_idx_q, max_idx_d;
   logic [CNT_W-1:0] min_idx_q, min_idx_d;
`endif

   logic             accept;
   logic [W-1:0]     cmp_b;
   logic [1:0]       cmp_code;

   assign in_ready = (state_q == ACCEPT);
   assign accept   = in_valid && in_ready;

   // One comparator shared between the max and min steps
   assign cmp_b = (state_q == CMP_MAX) ? max_q : min_q;

   mag_cmp5 #(
      .W (W)
   ) u_cmp (
      .a    (smp_q),
      .b    (cmp_b),
      .code (cmp_code)
   );

   always_comb begin
      state_d     = state_q;
      smp_d       = smp_q;
      max_d       = max_q;
      min_d       = min_q;
      cnt_d       = cnt_q;
      cnt_res_d   = cnt_res_q;
      ovf_d       = ovf_q;
      res_valid_d = res_valid_q;
      done_d      = 1'b0;
      last_d      = last_q;
`ifdef CMP_MINMAX_IDX_EN
      smp_idx_d   = smp_idx_q;
      max_idx_d   = max_idx_q;
      min_idx_d   = min_idx_q;
`endif

      case (state_q)
         ACCEPT: begin
            if (accept) begin
               smp_d  = in_data;
               last_d = in_last;
`ifdef CMP_MINMAX_IDX_EN
               // Pre-increment count is the 0-based index, saturating with it
               smp_idx_d = cnt_q;
`endif
               if (cnt_q == CNT_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               if (cnt_q == '0) begin
                  max_d       = in_data;
                  min_d       = in_data;
                  res_valid_d = 1'b0;
                  ovf_d       = 1'b0;
`ifdef CMP_MINMAX_IDX_EN
                  max_idx_d   = '0;
                  min_idx_d   = '0;
`endif
                  state_d     = in_last ? DONE : ACCEPT;
               end else begin
                  state_d = CMP_MAX;
               end
            end
         end

         CMP_MAX: begin
            if (cmp_code == CMP_GT) begin
               max_d = smp_q;
`ifdef CMP_MINMAX_IDX_EN
               max_idx_d = smp_idx_q;
`endif
            end
            state_d = CMP_MIN;
         end

         CMP_MIN: begin
            if (cmp_code == CMP_LT) begin
               min_d = smp_q;
`ifdef CMP_MINMAX_IDX_EN
               min_idx_d = smp_idx_q;
`endif
            end
            state_d = last_q ? DONE : ACCEPT;
         end

         DONE: begin
            done_d      = 1'b1;
            res_valid_d = 1'b1;
            // Freeze the result count so the live counter can restart
            cnt_res_d   = cnt_q;
            cnt_d       = '0;
            state_d     = ACCEPT;
         end

         default: state_d = ACCEPT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCEPT;
         smp_q       <= '0;
         max_q       <= '0;
         min_q       <= '0;
         cnt_q       <= '0;
         cnt_res_q   <= '0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         last_q      <= 1'b0;
`ifdef CMP_MINMAX_IDX_EN
         smp_idx_q   <= '0;
         max_idx_q   <= '0;
         min_idx_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         smp_q       <= smp_d;
         max_q       <= max_d;
         min_q       <= min_d;
         cnt_q       <= cnt_d;
         cnt_res_q   <= cnt_res_d;
         ovf_q       <= ovf_d;
         res_valid_q <= res_valid_d;
         done_q      <= done_d;
         last_q      <= last_d;
`ifdef CMP_MINMAX_IDX_EN
         smp_idx_q   <= smp_idx_d;
         max_idx_q   <= max_idx_d;
         min_idx_q   <= min_idx_d;
`endif
      end
   end

   assign max_val   = max_q;
   assign min_val   = min_q;
   // Live count while a burst runs, frozen result count once it completes
   assign count     = res_valid_q ? cnt_res_q : cnt_q;
   assign ovf       = ovf_q;
   assign res_valid = res_valid_q;
   assign done      = done_q;
`ifdef CMP_MINMAX_IDX_EN
   assign max_idx   = max_idx_q;
   assign min_idx   = min_idx_q;
`endif

endmodule : cmp_minmax_seq
`default_nettype wire

// File: tb/tb_cmp_minmax_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_minmax_seq
// Purpose  : Self-checking bench for cmp_minmax_seq: table of bursts with
//            expected results, scoreboard checked on each done pulse, plus a
//            mid-burst reset sequence.
// Options  : CMP_MINMAX_IDX_EN also checks max_idx/min_idx
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_minmax_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [4:0] max_val;
   logic [4:0] min_val;
   logic [3:0] count;
   logic       ovf;
   logic       res_valid;
   logic       done;
`ifdef CMP_MINMAX_IDX_EN
   logic [3:0] max_idx;
   logic [3:0] min_idx;
`endif

   always #5 clk = ~clk;

   cmp_minmax_seq #(
      .W     (5),
      .CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .max_val   (max_val),
      .min_val   (min_val),
      .count     (count),
      .ovf       (ovf),
      .res_valid (res_valid),
`ifdef CMP_MINMAX_IDX_EN
      .max_idx   (max_idx),
      .min_idx   (min_idx),
`endif
      .done      (done)
   );

   typedef struct {
      int off; int len;
      int mx; int mn; int cnt; int ov; int mxi; int mni;
   } vec_t;

   typedef struct {
      int mx; int mn; int cnt; int ov; int mxi; int mni; int cyc;
   } exp_t;

   int   pool [$];
   vec_t tv [7];
   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   pushes = 0;
   int   dones  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         dones++;
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("max_val", 32'(max_val), e.mx);
            check("min_val", 32'(min_val), e.mn);
            check("count", 32'(count), e.cnt);
            check("ovf", 32'(ovf), e.ov);
            check("res_valid", 32'(res_valid), 1);
`ifdef CMP_MINMAX_IDX_EN
            check("max_idx", 32'(max_idx), e.mxi);
            check("min_idx", 32'(min_idx), e.mni);
`endif
         end
      end
   end

   task automatic run_burst(input vec_t v);
      int   waits;
      int   first_cyc;
      exp_t e;
      for (int i = 0; i < v.len; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 5'(pool[v.off + i]);
         in_last  = (i == v.len - 1);
         waits    = 0;
         while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
         end
         if (!in_ready) begin
            check("ready_timeout", waits, 2);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (i == 0) begin
            first_cyc = cyc;
            e = '{v.mx, v.mn, v.cnt, v.ov, v.mxi, v.mni, first_cyc + 3 * v.len - 2};
            sb.push_back(e);
            pushes++;
         end
         // Sample i>=2 follows a compared sample: two stall cycles expected
         if (i >= 2) check("ready_stall", waits, 2);
         if (i == 1) check("ready_stall_first", waits, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("drain", sb.size(), 0);
   endtask

   initial begin
      pool = '{7, 3, 12, 3,
               0,
               5, 5, 5,
               10, 4, 22, 9, 17, 30, 2, 8, 15, 3, 6, 19, 25, 11, 13, 5, 1,
               20, 31, 0, 31,
               1, 2, 3,
               31, 0};
      //        off len  mx  mn cnt ov mxi mni
      tv[0] = '{ 0,  4, 12,  3,  4, 0,  2,  1};
      tv[1] = '{ 4,  1,  0,  0,  1, 0,  0,  0};
      tv[2] = '{ 5,  3,  5,  5,  3, 0,  0,  0};
      tv[3] = '{ 8, 17, 30,  1, 15, 1,  5, 15};
      tv[4] = '{25,  4, 31,  0,  4, 0,  1,  2};
      tv[5] = '{29,  3,  3,  1,  3, 0,  2,  0};
      tv[6] = '{32,  2, 31,  0,  2, 0,  0,  1};

      rst_n    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_max", 32'(max_val), 0);
      check("rst_count", 32'(count), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_burst(tv[i]);
         wait_drain();
         if (i == 0) begin
            // Result must hold while idle
            repeat (3) @(negedge clk);
            check("hold_max", 32'(max_val), 12);
            check("hold_min", 32'(min_val), 3);
            check("hold_count", 32'(count), 4);
            check("hold_res_valid", 32'(res_valid), 1);
            check("hold_done_low", 32'(done), 0);
         end
      end

      // Mid-burst reset: accept two samples, then reset while in CMP_MIN
      @(negedge clk);
      in_valid = 1'b1; in_data = 5'd10; in_last = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_data = 5'd20;
      check("abort_ready2", 32'(in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      check("abort_ready_cmp", 32'(in_ready), 0);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_max", 32'(max_val), 0);
      check("abort_min", 32'(min_val), 0);
      check("abort_count", 32'(count), 0);
      check("abort_ovf", 32'(ovf), 0);
      check("abort_res_valid", 32'(res_valid), 0);
      check("abort_done", 32'(done), 0);
      check("abort_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_burst(tv[6]);
      wait_drain();

      repeat (4) @(negedge clk);
      check("done_total", dones, pushes);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule : tb_cmp_minmax_seq
`default_nettype wire
